// File: rtl/dat_mem_arb.sv
// Round-robin arbiter and word-access sequencer sharing one data memory
// between port 0 (CPU) and port 1 (DMA/debug loader).
module dat_mem_arb #(
    parameter int unsigned MEM_BYTES = 128,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_wr,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic [31:0] p0_rdata,
    output logic        p0_ack,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_wr,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic [31:0] p1_rdata,
    output logic        p1_ack,
    output logic        p1_err,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int unsigned CNT_W    = 3;
    localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             state, next_state;
    logic               gnt;
    logic               last;
    logic               wr_q;
    logic               err_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        rdata0_q, rdata1_q;

    logic               any_req;
    logic               win;
    logic               win_wr;
    logic [31:0]        win_addr;
    logic [31:0]        win_wdata;
    logic               win_bad;

    // Winner: the only requester, or the one not granted last on contention
    always_comb begin
        any_req   = p0_req | p1_req;
        win       = (p0_req & p1_req) ? ~last : p1_req;
        win_wr    = win ? p1_wr    : p0_wr;
        win_addr  = win ? p1_addr  : p0_addr;
        win_wdata = win ? p1_wdata : p0_wdata;
        win_bad   = (win_addr[1:0] != 2'b00) || (win_addr > MAX_ADDR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    next_state = win_bad ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (wr_q || (cnt == '0)) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Grant latch, read-latency countdown and per-port read-data holding registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt      <= 1'b0;
            last     <= 1'b1;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt      <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                gnt     <= win;
                last    <= win;
                wr_q    <= win_wr;
                err_q   <= win_bad;
                addr_q  <= win_addr;
                wdata_q <= win_wdata;
                cnt     <= CNT_W'(RD_LAT - 1);
                if (win_bad) begin
                    if (win) begin
                        rdata1_q <= '0;
                    end else begin
                        rdata0_q <= '0;
                    end
                end
            end
            if (state == ACCESS && !wr_q) begin
                if (cnt == '0) begin
                    if (gnt) begin
                        rdata1_q <= mem_rdata;
                    end else begin
                        rdata0_q <= mem_rdata;
                    end
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
        end
    end

    // Memory strobes exist only in ACCESS; acks only in RESP
    always_comb begin
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        p0_ack    = 1'b0;
        p0_err    = 1'b0;
        p1_ack    = 1'b0;
        p1_err    = 1'b0;
        busy      = (state != IDLE);
        case (state)
            ACCESS: begin
                mem_addr  = addr_q;
                mem_wr    = wr_q;
                mem_wdata = wr_q ? wdata_q : '0;
            end
            RESP: begin
                p0_ack = ~gnt;
                p0_err = ~gnt & err_q;
                p1_ack = gnt;
                p1_err = gnt & err_q;
            end
            default: ;
        endcase
    end

    assign p0_rdata = rdata0_q;
    assign p1_rdata = rdata1_q;

endmodule

// File: tb/tb_dat_mem_arb.sv
// Directed bench for dat_mem_arb: instance A (RD_LAT=1) runs a vector table
// plus contention/drop-req sequences; instance B (RD_LAT=3) covers slow reads and reset abort.
module tb_dat_mem_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A signals
    logic        a_rst;
    logic        a_p0_req, a_p0_wr, a_p1_req, a_p1_wr;
    logic [31:0] a_p0_addr, a_p0_wdata, a_p1_addr, a_p1_wdata;
    logic [31:0] a_p0_rdata, a_p1_rdata;
    logic        a_p0_ack, a_p0_err, a_p1_ack, a_p1_err;
    logic        a_mem_wr, a_busy;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

    // Instance B signals
    logic        b_rst;
    logic        b_p0_req, b_p0_wr, b_p1_req, b_p1_wr;
    logic [31:0] b_p0_addr, b_p0_wdata, b_p1_addr, b_p1_wdata;
    logic [31:0] b_p0_rdata, b_p1_rdata;
    logic        b_p0_ack, b_p0_err, b_p1_ack, b_p1_err;
    logic        b_mem_wr, b_busy;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    dat_mem_arb #(.MEM_BYTES(128), .RD_LAT(1)) u_dut_a (
        .clk(clk), .rst(a_rst),
        .p0_req(a_p0_req), .p0_wr(a_p0_wr), .p0_addr(a_p0_addr), .p0_wdata(a_p0_wdata),
        .p0_rdata(a_p0_rdata), .p0_ack(a_p0_ack), .p0_err(a_p0_err),
        .p1_req(a_p1_req), .p1_wr(a_p1_wr), .p1_addr(a_p1_addr), .p1_wdata(a_p1_wdata),
        .p1_rdata(a_p1_rdata), .p1_ack(a_p1_ack), .p1_err(a_p1_err),
        .mem_wr(a_mem_wr), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    dat_mem_arb #(.MEM_BYTES(128), .RD_LAT(3)) u_dut_b (
        .clk(clk), .rst(b_rst),
        .p0_req(b_p0_req), .p0_wr(b_p0_wr), .p0_addr(b_p0_addr), .p0_wdata(b_p0_wdata),
        .p0_rdata(b_p0_rdata), .p0_ack(b_p0_ack), .p0_err(b_p0_err),
        .p1_req(b_p1_req), .p1_wr(b_p1_wr), .p1_addr(b_p1_addr), .p1_wdata(b_p1_wdata),
        .p1_rdata(b_p1_rdata), .p1_ack(b_p1_ack), .p1_err(b_p1_err),
        .mem_wr(b_mem_wr), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    // Memory models: A reads within the address cycle, B after a 3-cycle pipeline
    logic [31:0] mem_a [0:31];
    logic [31:0] mem_b [0:31];
    logic [4:0]  b_d1, b_d2;

    assign a_mem_rdata = mem_a[a_mem_addr[6:2]];
    assign b_mem_rdata = mem_b[b_d2];

    always @(posedge clk) begin
        if (a_mem_wr) mem_a[a_mem_addr[6:2]] <= a_mem_wdata;
        if (b_mem_wr) mem_b[b_mem_addr[6:2]] <= b_mem_wdata;
        b_d1 <= b_mem_addr[6:2];
        b_d2 <= b_d1;
    end

    typedef struct {
        logic        port;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic a_drive(input logic port, input logic req, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            a_p1_req = req; a_p1_wr = wr; a_p1_addr = addr; a_p1_wdata = wdata;
        end else begin
            a_p0_req = req; a_p0_wr = wr; a_p0_addr = addr; a_p0_wdata = wdata;
        end
    endtask

    // Issue one transaction on A, measure ack latency, strobes and response fields
    task automatic run_vec(input int idx, input vec_t v);
        int          lat;
        int          nwr;
        bit          done;
        bit          other;
        logic        err_s;
        logic [31:0] rd_s;
        lat = 0; nwr = 0; done = 0; other = 0; err_s = 1'b0; rd_s = '0;
        @(negedge clk);
        a_drive(v.port, 1'b1, v.wr, v.addr, v.wdata);
        while (!done && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (a_mem_wr) begin
                nwr++;
                check($sformatf("v%0d_mem_addr", idx), a_mem_addr, v.addr);
                check($sformatf("v%0d_mem_wdata", idx), a_mem_wdata, v.wdata);
            end
            if (v.port ? a_p0_ack : a_p1_ack) other = 1;
            if (v.port ? a_p1_ack : a_p0_ack) begin
                done  = 1;
                err_s = v.port ? a_p1_err : a_p0_err;
                rd_s  = v.port ? a_p1_rdata : a_p0_rdata;
            end
        end
        a_drive(v.port, 1'b0, 1'b0, 32'h0, 32'h0);
        check($sformatf("v%0d_ack_seen", idx), 32'(done), 32'd1);
        check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
        check($sformatf("v%0d_err", idx), 32'(err_s), 32'(v.exp_err));
        check($sformatf("v%0d_rdata", idx), rd_s, v.exp_rdata);
        check($sformatf("v%0d_mem_wr_cycles", idx), 32'(nwr), (v.wr && !v.exp_err) ? 32'd1 : 32'd0);
        check($sformatf("v%0d_other_ack", idx), 32'(other), 32'd0);
    endtask

    initial begin
        int          n;
        int          both;
        int          acks;
        int          nwr;
        int          lat;
        bit          done;
        logic        order [4];
        logic        first;

        for (int i = 0; i < 32; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        mem_b[4] = 32'hDEADBEEF;
        b_d1 = '0; b_d2 = '0;

        //        port  wr    addr           wdata          err   rdata          lat
        vecs[0]  = '{1'b0, 1'b1, 32'h00000010, 32'hDEADBEEF, 1'b0, 32'h00000000, 2};
        vecs[1]  = '{1'b0, 1'b0, 32'h00000010, 32'h00000000, 1'b0, 32'hDEADBEEF, 2};
        vecs[2]  = '{1'b1, 1'b1, 32'h0000007C, 32'h12345678, 1'b0, 32'h00000000, 2};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000007C, 32'h00000000, 1'b0, 32'h12345678, 2};
        vecs[4]  = '{1'b1, 1'b1, 32'h00000012, 32'h11111111, 1'b1, 32'h00000000, 1};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000007D, 32'h00000000, 1'b1, 32'h00000000, 1};
        vecs[6]  = '{1'b1, 1'b1, 32'h80000000, 32'h22222222, 1'b1, 32'h00000000, 1};
        vecs[7]  = '{1'b0, 1'b0, 32'h00000080, 32'h00000000, 1'b1, 32'h00000000, 1};
        vecs[8]  = '{1'b0, 1'b0, 32'h0000007C, 32'h00000000, 1'b0, 32'h12345678, 2};
        vecs[9]  = '{1'b1, 1'b0, 32'h00000010, 32'h00000000, 1'b0, 32'hDEADBEEF, 2};
        vecs[10] = '{1'b0, 1'b1, 32'h00000000, 32'hA5A5A5A5, 1'b0, 32'h12345678, 2};
        vecs[11] = '{1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 32'hA5A5A5A5, 2};

        a_rst = 1'b1; b_rst = 1'b1;
        a_drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        a_drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        b_p0_req = 1'b0; b_p0_wr = 1'b0; b_p0_addr = '0; b_p0_wdata = '0;
        b_p1_req = 1'b0; b_p1_wr = 1'b0; b_p1_addr = '0; b_p1_wdata = '0;
        repeat (2) @(negedge clk);

        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_mem_wr", 32'(a_mem_wr), 32'd0);
        check("rst_mem_addr", a_mem_addr, 32'h0);
        check("rst_mem_wdata", a_mem_wdata, 32'h0);
        check("rst_acks", {28'h0, a_p0_ack, a_p0_err, a_p1_ack, a_p1_err}, 32'h0);
        check("rst_rdata", a_p0_rdata | a_p1_rdata, 32'h0);
        a_rst = 1'b0; b_rst = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);
        check("mem_0x10", mem_a[4], 32'hDEADBEEF);
        check("mem_0x7c", mem_a[31], 32'h12345678);

        // Both ports request from reset and hold: grants must alternate p0, p1, p0, p1
        @(negedge clk);
        a_rst = 1'b1;
        a_drive(1'b0, 1'b1, 1'b0, 32'h00000010, 32'h0);
        a_drive(1'b1, 1'b1, 1'b0, 32'h0000007C, 32'h0);
        @(negedge clk);
        a_rst = 1'b0;
        n = 0; both = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (a_p0_ack && a_p1_ack) both++;
            if (a_p0_ack || a_p1_ack) begin
                order[n] = a_p1_ack;
                n++;
            end
        end
        a_drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        a_drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("rr_ack_count", 32'(n), 32'd4);
        for (int k = 0; k < 4; k++)
            check($sformatf("rr_grant%0d", k), 32'(order[k]), 32'(k % 2));
        check("rr_double_ack", 32'(both), 32'd0);

        // p0 drops req one cycle after grant during a write; transaction must still complete
        @(negedge clk);
        @(negedge clk);
        a_drive(1'b0, 1'b1, 1'b1, 32'h00000020, 32'hCAFEF00D);
        @(posedge clk);
        @(negedge clk);
        a_drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        nwr = a_mem_wr ? 1 : 0;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (a_mem_wr) nwr++;
            if (a_p0_ack) acks++;
        end
        check("drop_mem_wr_cycles", 32'(nwr), 32'd1);
        check("drop_ack_count", 32'(acks), 32'd1);
        check("drop_busy_idle", 32'(a_busy), 32'd0);
        check("drop_mem_0x20", mem_a[8], 32'hCAFEF00D);

        // RD_LAT=3 read on B
        @(negedge clk);
        b_p0_req = 1'b1; b_p0_wr = 1'b0; b_p0_addr = 32'h00000010;
        lat = 0; done = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (b_p0_ack) done = 1;
        end
        check("b_ack_seen", 32'(done), 32'd1);
        check("b_rd_latency", 32'(lat), 32'd4);
        check("b_rdata", b_p0_rdata, 32'hDEADBEEF);
        check("b_err", 32'(b_p0_err), 32'd0);
        b_p0_req = 1'b0;

        // Reset during a B read: everything clears at once, then p0 wins first contention
        @(negedge clk);
        b_p0_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("b_busy_access", 32'(b_busy), 32'd1);
        @(posedge clk);
        #2;
        b_rst = 1'b1;
        #1;
        check("b_rst_busy", 32'(b_busy), 32'd0);
        check("b_rst_mem", {31'h0, b_mem_wr} | b_mem_addr | b_mem_wdata, 32'h0);
        check("b_rst_acks", {28'h0, b_p0_ack, b_p0_err, b_p1_ack, b_p1_err}, 32'h0);
        check("b_rst_rdata", b_p0_rdata | b_p1_rdata, 32'h0);
        b_p0_req = 1'b0;
        @(negedge clk);
        b_rst = 1'b0;
        b_p0_req = 1'b1; b_p0_addr = 32'h00000010;
        b_p1_req = 1'b1; b_p1_wr = 1'b0; b_p1_addr = 32'h00000010;
        done = 0; first = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (b_p0_ack || b_p1_ack) begin
                done  = 1;
                first = b_p1_ack;
            end
        end
        b_p0_req = 1'b0; b_p1_req = 1'b0;
        check("b_post_rst_ack_seen", 32'(done), 32'd1);
        check("b_post_rst_first_grant", 32'(first), 32'd0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
